// File: rtl/ldw_wb_regfile.sv
// MEM/WB write-back stage: selects the write-back value, commits it to a 32-entry
// register file, and serves two bypassed ID read ports, a debug port and a write counter.
module ldw_wb_rdport #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clrn,
   input  logic              byp_en,
   input  logic [ADDR_W-1:0] rn,
   input  logic [ADDR_W-1:0] wrn,
   input  logic [DATA_W-1:0] wdi,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] q
);
   always_comb begin
      q = rf_data;
      if (!clrn || rn == '0)
         q = '0;
      else if (byp_en && wrn == rn)
         q = wdi;
   end
endmodule

module ldw_wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              wwreg,
   input  logic              wm2reg,
   input  logic [DATA_W-1:0] wmo,
   input  logic [DATA_W-1:0] walu,
   input  logic [ADDR_W-1:0] wrn,
   input  logic [ADDR_W-1:0] rna,
   input  logic [ADDR_W-1:0] rnb,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb,
   output logic [DATA_W-1:0] wdi,
   input  logic [ADDR_W-1:0] dbg_rn,
   output logic [DATA_W-1:0] dbg_q,
   output logic [CNT_W-1:0]  wr_cnt
);
   localparam int NREG  = 1 << ADDR_W;
   localparam int NPORT = 2;

   logic [DATA_W-1:0] rf [NREG];
   logic              commit;

   logic [NPORT-1:0][ADDR_W-1:0] rn_all;
   logic [NPORT-1:0][DATA_W-1:0] rd_all;
   logic [NPORT-1:0][DATA_W-1:0] q_all;

   assign wdi    = wm2reg ? wmo : walu;
   assign commit = wwreg && (wrn != '0);

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         dbg_q  <= '0;
         wr_cnt <= '0;
      end else begin
         dbg_q <= (dbg_rn == '0) ? '0 : rf[dbg_rn];
         if (commit) begin
            rf[wrn] <= wdi;
            wr_cnt  <= wr_cnt + CNT_W'(1);
         end
      end
   end

   assign rn_all[0] = rna;
   assign rn_all[1] = rnb;

   genvar p;
   generate
      for (p = 0; p < NPORT; p++) begin : g_rd
         assign rd_all[p] = rf[rn_all[p]];
         ldw_wb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
            .clrn    (clrn),
            .byp_en  (commit),
            .rn      (rn_all[p]),
            .wrn     (wrn),
            .wdi     (wdi),
            .rf_data (rd_all[p]),
            .q       (q_all[p])
         );
      end
   endgenerate

   assign qa = q_all[0];
   assign qb = q_all[1];
endmodule

// File: tb/tb_ldw_wb_regfile.sv
// Directed bench for ldw_wb_regfile: array-based reference model checked every cycle,
// plus literal expectations taken straight from the hand-worked test plan.
module tb_ldw_wb_regfile;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 4;

   logic              clk = 0;
   logic              clrn;
   logic              wwreg, wm2reg;
   logic [DATA_W-1:0] wmo, walu;
   logic [ADDR_W-1:0] wrn, rna, rnb, dbg_rn;
   logic [DATA_W-1:0] qa, qb, wdi, dbg_q;
   logic [CNT_W-1:0]  wr_cnt;

   int errors = 0;
   int checks = 0;
   bit started = 0;

   ldw_wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
      .wrn(wrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb), .wdi(wdi),
      .dbg_rn(dbg_rn), .dbg_q(dbg_q), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: plain register array, counter and debug latch.
   logic [DATA_W-1:0] mreg [32];
   logic [DATA_W-1:0] mdbg;
   logic [CNT_W-1:0]  mcnt;

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < 32; i++) mreg[i] <= '0;
         mdbg <= '0;
         mcnt <= '0;
      end else begin
         mdbg <= mreg[dbg_rn];
         if (wwreg && wrn != 0) begin
            mreg[wrn] <= wm2reg ? wmo : walu;
            mcnt <= mcnt + 1'b1;
         end
      end
   end

   function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] rn);
      if (!clrn || rn == 0) return '0;
      if (wwreg && wrn != 0 && wrn == rn) return wm2reg ? wmo : walu;
      return mreg[rn];
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model_qa", qa, exp_rd(rna));
         chk("model_qb", qb, exp_rd(rnb));
         chk("model_wdi", wdi, wm2reg ? wmo : walu);
         chk("model_dbg", dbg_q, mdbg);
         chk("model_cnt", DATA_W'(wr_cnt), DATA_W'(mcnt));
      end
   end

   // Inputs change 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] rn, input logic [DATA_W-1:0] val);
      step();
      wwreg = 1; wm2reg = 0; wrn = rn; walu = val;
   endtask

   task automatic idle();
      step();
      wwreg = 0;
   endtask

   initial begin
      clrn = 0; wwreg = 0; wm2reg = 0; wmo = 0; walu = 0;
      wrn = 0; rna = 0; rnb = 0; dbg_rn = 0;
      #2;
      chk("reset_cnt", DATA_W'(wr_cnt), 0);
      chk("reset_dbg", dbg_q, 0);
      clrn = 1;
      started = 1;

      // reset clears a preloaded register immediately
      wr(5, 32'h1234_5678);
      idle(); rna = 5;
      #2 chk("preload_r5", qa, 32'h1234_5678);
      clrn = 0;
      #1 chk("rst_qa_async", qa, 0);
      chk("rst_cnt_async", DATA_W'(wr_cnt), 0);
      clrn = 1;
      idle();
      #2 chk("rst_r5_after", qa, 0);

      // ALU write-back with same-cycle bypass
      wr(7, 32'hDEAD_BEEF); rna = 7;
      #2 chk("alu_bypass_qa", qa, 32'hDEAD_BEEF);
      chk("alu_wdi", wdi, 32'hDEAD_BEEF);
      idle();
      #2 chk("alu_held_qa", qa, 32'hDEAD_BEEF);
      chk("alu_cnt", DATA_W'(wr_cnt), 1);

      // load write-back, both ports on the same index
      step();
      wwreg = 1; wm2reg = 1; wmo = 32'h0000_00A5; walu = 32'hFFFF_FFFF; wrn = 3; rna = 3; rnb = 3;
      #2 chk("ld_qa", qa, 32'hA5);
      chk("ld_qb", qb, 32'hA5);
      idle(); wm2reg = 0; walu = 32'h0BAD_0BAD;
      #2 chk("ld_r3", qa, 32'hA5);
      chk("ld_r3_b", qb, 32'hA5);

      // r0 is hardwired zero and not counted
      wr(0, 32'h1); rna = 0;
      #2 chk("r0_before", qa, 0);
      idle();
      #2 chk("r0_after", qa, 0);
      chk("r0_cnt", DATA_W'(wr_cnt), 2);

      // debug port: one-cycle latency, pre-write contents
      wr(9, 32'h11);
      wr(9, 32'h55); dbg_rn = 9;
      idle();
      #2 chk("dbg_old", dbg_q, 32'h11);
      idle();
      #2 chk("dbg_new", dbg_q, 32'h55);

      // back-to-back writes to one register, last wins
      wr(4, 32'hAAAA_0001);
      wr(4, 32'hBBBB_0002);
      idle(); rna = 4; rnb = 9;
      #2 chk("b2b_last", qa, 32'hBBBB_0002);
      chk("b2b_cnt", DATA_W'(wr_cnt), 6);

      // mixed traffic with both ports reading around the write index
      for (int i = 1; i < 12; i++) begin
         wr(ADDR_W'(i), 32'h100 * i + 32'h7); rna = ADDR_W'(i); rnb = ADDR_W'(i - 1);
         dbg_rn = ADDR_W'(i - 1);
      end
      idle();

      // reset asserted across an edge performs no write
      step(); wwreg = 1; walu = 32'hCAFE; wrn = 2; clrn = 0;
      idle(); clrn = 1; rna = 2;
      #2 chk("rst_edge_nowrite", qa, 0);

      // counter wraps modulo 16
      for (int i = 1; i <= 17; i++) wr(ADDR_W'(i), 32'(i));
      idle();
      #2 chk("wrap_cnt", DATA_W'(wr_cnt), 1);
      for (int i = 0; i < 3; i++) begin
         idle(); walu = 32'hFFFF_0000; wm2reg = 1;
         #2 chk("wrap_hold", DATA_W'(wr_cnt), 1);
      end
      idle();

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
